// File: rtl/uart_pkg.sv
// uart_pkg: shared register addresses, UCR layout, USR bit indices and frame states
package uart_pkg;
  localparam logic [10:0] UDR_DEF = 11'h402;
  localparam logic [10:0] UCR_DEF = 11'h403;
  localparam logic [10:0] USR_DEF = 11'h404;
  localparam logic [10:0] UBR_DEF = 11'h405;
  typedef struct packed {
    logic errie;
    logic txie;
    logic rxie;
    logic db7;
    logic stop2;
    logic podd;
    logic pen;
  } ucr_t;
  localparam int USR_RXE = 0;
  localparam int USR_TXF = 1;
  localparam int USR_TXE = 2;
  localparam int USR_TXBUSY = 3;
  localparam int USR_PE = 4;
  localparam int USR_FE = 5;
  localparam int USR_OE = 6;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} frame_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word fall-through read port
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign empty = count == '0;
  assign full = count == FULL_CNT;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: rx synchroniser, frame receiver and parity/framing error detection
module uart_rx_frame import uart_pkg::*; #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] div,
  input  logic        pen,
  input  logic        podd,
  input  logic        db7,
  output logic        push,
  output logic [7:0]  data,
  output logic        pe_set,
  output logic        fe_set
);
  frame_state_e state, state_n;
  logic rx_s1, rx_s2, rx_d;
  logic [15:0] cnt, div_l;
  logic [2:0] bit_idx, last_idx, data_idx;
  logic par, pe_err, pen_l, podd_l, db7_l, tick, fall;
  assign tick = cnt == '0;
  assign fall = rx_d && !rx_s2;
  assign last_idx = db7_l ? 3'd6 : 3'd7;
  assign data_idx = LSB_FIRST ? bit_idx : last_idx - bit_idx;
  always_comb begin
    state_n = state;
    push = 1'b0;
    pe_set = 1'b0;
    fe_set = 1'b0;
    case (state)
      IDLE: state_n = fall ? START : IDLE;
      START: if (tick) state_n = rx_s2 ? IDLE : DATA;
      DATA: if (tick && bit_idx == last_idx) state_n = pen_l ? PARITY : STOP;
      PARITY: if (tick) state_n = STOP;
      STOP: if (tick) begin
        push = 1'b1;
        pe_set = pe_err;
        fe_set = !rx_s2;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d <= 1'b1;
      cnt <= '0;
      div_l <= 16'd4;
      bit_idx <= '0;
      par <= 1'b0;
      pe_err <= 1'b0;
      pen_l <= 1'b0;
      podd_l <= 1'b0;
      db7_l <= 1'b0;
      data <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d <= rx_s2;
      state <= state_n;
      if (state == IDLE) begin
        cnt <= (div >> 1) - 16'd1;
        div_l <= div;
        pen_l <= pen;
        podd_l <= podd;
        db7_l <= db7;
        bit_idx <= '0;
        par <= 1'b0;
        pe_err <= 1'b0;
        data <= '0;
      end else begin
        cnt <= tick ? div_l - 16'd1 : cnt - 16'd1;
        if (tick && state == DATA) begin
          data[data_idx] <= rx_s2;
          par <= par ^ rx_s2;
          bit_idx <= bit_idx + 3'd1;
        end
        if (tick && state == PARITY) pe_err <= par ^ rx_s2 ^ podd_l;
      end
    end
  end
endmodule

// File: rtl/uart_cfg.sv
// uart_cfg: memory-mapped UART with programmable framing, baud divisor, sticky errors and irq
module uart_cfg import uart_pkg::*; #(
  parameter logic [15:0] DIV_RESET = 16'd868,
  parameter int FIFO_DEPTH = 16,
  parameter bit LSB_FIRST = 1'b1,
  parameter logic [10:0] UDR_ADDR = UDR_DEF,
  parameter logic [10:0] UCR_ADDR = UCR_DEF,
  parameter logic [10:0] USR_ADDR = USR_DEF,
  parameter logic [10:0] UBR_ADDR = UBR_DEF,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  input  logic [10:0] addr,
  input  logic [31:0] wrData,
  input  logic        wrEn,
  input  logic        rdEn,
  output logic [31:0] dataOut,
  output logic        outEn,
  output logic        irq,
  output logic        rxFfEmpty
);
  ucr_t ucr;
  logic [15:0] ubr, div, tx_cnt, tx_div;
  logic pe, fe, oe, pe_set, fe_set, oe_set;
  logic hit_udr, hit_ucr, hit_usr, hit_ubr, rd_hit, usr_clr;
  logic rx_push, rx_pop, rx_full, tx_push, tx_pop, tx_empty, tx_full, tx_busy;
  logic [7:0] rx_data, rx_head, tx_head, tx_byte, tx_shreg, rx_cnt_sat;
  logic [CW-1:0] rx_count, unused_tx_count;
  logic [8:0] rx_cnt9;
  logic [31:0] usr, rd_val;
  logic unused_wr;
  frame_state_e tx_state, tx_state_n;
  logic [2:0] tx_bit, tx_last, tx_idx;
  logic tx_stop, tx_par, tx_pen, tx_stop2, tx_db7, tx_tick;
  assign unused_wr = ^wrData[31:16];
  assign div = ubr < 16'd4 ? 16'd4 : ubr;
  assign hit_udr = addr == UDR_ADDR;
  assign hit_ucr = addr == UCR_ADDR;
  assign hit_usr = addr == USR_ADDR;
  assign hit_ubr = addr == UBR_ADDR;
  assign rd_hit = rdEn && (hit_udr || hit_ucr || hit_usr || hit_ubr);
  assign usr_clr = wrEn && hit_usr;
  assign rx_pop = rdEn && hit_udr && !rxFfEmpty;
  assign tx_push = wrEn && hit_udr;
  assign oe_set = rx_push && rx_full;
  assign rx_cnt9 = 9'(rx_count);
  assign rx_cnt_sat = rx_cnt9[8] ? 8'hff : rx_cnt9[7:0];
  assign tx_busy = tx_state != IDLE;
  assign usr = {16'b0, rx_cnt_sat, 1'b0, oe, fe, pe, tx_busy, tx_empty, tx_full, rxFfEmpty};
  assign rd_val = hit_udr ? (rxFfEmpty ? 32'b0 : {24'b0, rx_head}) :
                  hit_ucr ? {25'b0, ucr} :
                  hit_usr ? usr :
                  hit_ubr ? {16'b0, ubr} : 32'b0;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_data), .pop(rx_pop),
    .dout(rx_head), .empty(rxFfEmpty), .full(rx_full), .count(rx_count)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(wrData[7:0]), .pop(tx_pop),
    .dout(tx_head), .empty(tx_empty), .full(tx_full), .count(unused_tx_count)
  );
  uart_rx_frame #(.LSB_FIRST(LSB_FIRST)) u_rx (
    .clk(clk), .rst(rst), .rx(rx), .div(div), .pen(ucr.pen), .podd(ucr.podd), .db7(ucr.db7),
    .push(rx_push), .data(rx_data), .pe_set(pe_set), .fe_set(fe_set)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      ucr <= '0;
      ubr <= DIV_RESET;
      pe <= 1'b0;
      fe <= 1'b0;
      oe <= 1'b0;
      outEn <= 1'b0;
      dataOut <= '0;
      irq <= 1'b0;
    end else begin
      if (wrEn && hit_ucr) ucr <= ucr_t'(wrData[6:0]);
      if (wrEn && hit_ubr) ubr <= wrData[15:0];
      pe <= pe_set || (pe && !(usr_clr && wrData[USR_PE]));
      fe <= fe_set || (fe && !(usr_clr && wrData[USR_FE]));
      oe <= oe_set || (oe && !(usr_clr && wrData[USR_OE]));
      outEn <= rd_hit;
      dataOut <= rd_hit ? rd_val : '0;
      irq <= (ucr.rxie && !rxFfEmpty) || (ucr.txie && tx_empty && !tx_busy) || (ucr.errie && (pe || fe || oe));
    end
  end
  assign tx_tick = tx_cnt == '0;
  assign tx_last = tx_db7 ? 3'd6 : 3'd7;
  assign tx_idx = LSB_FIRST ? tx_bit : tx_last - tx_bit;
  assign tx_byte = ucr.db7 ? {1'b0, tx_head[6:0]} : tx_head;
  assign tx = tx_state == START ? 1'b0 :
              tx_state == DATA ? tx_shreg[tx_idx] :
              tx_state == PARITY ? tx_par : 1'b1;
  always_comb begin
    tx_state_n = tx_state;
    tx_pop = 1'b0;
    case (tx_state)
      IDLE: if (!tx_empty) begin
        tx_pop = 1'b1;
        tx_state_n = START;
      end
      START: if (tx_tick) tx_state_n = DATA;
      DATA: if (tx_tick && tx_bit == tx_last) tx_state_n = tx_pen ? PARITY : STOP;
      PARITY: if (tx_tick) tx_state_n = STOP;
      STOP: if (tx_tick && (tx_stop || !tx_stop2)) begin
        tx_pop = !tx_empty;
        tx_state_n = tx_empty ? IDLE : START;
      end
      default: tx_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt <= '0;
      tx_div <= 16'd4;
      tx_bit <= '0;
      tx_stop <= 1'b0;
      tx_shreg <= '0;
      tx_par <= 1'b0;
      tx_pen <= 1'b0;
      tx_stop2 <= 1'b0;
      tx_db7 <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_pop) begin
        tx_cnt <= div - 16'd1;
        tx_div <= div;
        tx_bit <= '0;
        tx_stop <= 1'b0;
        tx_shreg <= tx_byte;
        tx_par <= (^tx_byte) ^ ucr.podd;
        tx_pen <= ucr.pen;
        tx_stop2 <= ucr.stop2;
        tx_db7 <= ucr.db7;
      end else if (tx_state != IDLE) begin
        tx_cnt <= tx_tick ? tx_div - 16'd1 : tx_cnt - 16'd1;
        if (tx_tick && tx_state == DATA) tx_bit <= tx_bit + 3'd1;
        if (tx_tick && tx_state == STOP) tx_stop <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: directed self-checking bench for uart_cfg at a 16-cycle bit time
module tb_uart_cfg;
  localparam logic [10:0] UDR = 11'h402;
  localparam logic [10:0] UCR = 11'h403;
  localparam logic [10:0] USR = 11'h404;
  localparam logic [10:0] UBR = 11'h405;
  logic clk = 1'b0, rst = 1'b1, rx_drv = 1'b1, rx_idle = 1'b0, rx_line;
  logic tx, wrEn = 1'b0, rdEn = 1'b0, outEn, irq, rxFfEmpty;
  logic [10:0] addr = '0;
  logic [31:0] wrData = '0, dataOut, d, d2;
  logic cap [180];
  logic [9:0] exp_bits = 10'h2aa;
  logic [7:0] rx_vec [17] = '{8'h01, 8'h80, 8'hff, 8'h00, 8'h5a, 8'ha5, 8'h3c, 8'hc3, 8'h12,
                              8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde, 8'hf0, 8'h77};
  int n_tests = 0, n_fail = 0;
  assign rx_line = rx_drv | rx_idle;
  always #5 clk = ~clk;
  uart_cfg dut (
    .clk(clk), .rst(rst), .rx(rx_line), .tx(tx), .addr(addr), .wrData(wrData),
    .wrEn(wrEn), .rdEn(rdEn), .dataOut(dataOut), .outEn(outEn), .irq(irq), .rxFfEmpty(rxFfEmpty)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bus_write(input logic [10:0] a, input logic [31:0] v);
    @(negedge clk);
    addr = a;
    wrData = v;
    wrEn = 1'b1;
    @(negedge clk);
    wrEn = 1'b0;
  endtask
  task automatic bus_read(input logic [10:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = a;
    rdEn = 1'b1;
    @(negedge clk);
    rdEn = 1'b0;
    check("outEn", {31'b0, outEn}, 32'd1);
    v = dataOut;
  endtask
  task automatic send_rx(input logic [7:0] b, input logic pen, input logic par, input logic stop, input int idle_bits);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (16) @(negedge clk);
    end
    if (pen) begin
      rx_drv = par;
      repeat (16) @(negedge clk);
    end
    rx_drv = stop;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (16 * idle_bits) @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_outEn", {31'b0, outEn}, 32'd0);
    bus_read(UBR, d);
    check("rst_ubr", d, 32'd868);
    @(negedge clk);
    check("outEn_one_cycle", {31'b0, outEn}, 32'd0);
    check("dataOut_idle", dataOut, 32'd0);
    bus_read(UCR, d);
    check("rst_ucr", d, 32'd0);
    @(negedge clk);
    addr = 11'h400;
    rdEn = 1'b1;
    @(negedge clk);
    rdEn = 1'b0;
    check("unmapped_outEn", {31'b0, outEn}, 32'd0);
    bus_write(UBR, 32'd16);
    bus_write(UDR, 32'h55);
    fork
      for (int i = 0; i < 180; i++) begin
        cap[i] = tx;
        @(negedge clk);
      end
      begin
        repeat (79) @(negedge clk);
        bus_read(USR, d2);
        check("usr_busy", d2 & 32'hff, 32'h0d);
      end
    join
    check("tx_idle_pre", {31'b0, cap[0]}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("tx_bit_first", {31'b0, cap[1 + 16 * k]}, {31'b0, exp_bits[k]});
      check("tx_bit_last", {31'b0, cap[16 + 16 * k]}, {31'b0, exp_bits[k]});
    end
    check("tx_idle_post", {31'b0, cap[161]}, 32'd1);
    bus_read(USR, d);
    check("usr_tx_done", d & 32'hff, 32'h05);
    bus_write(UCR, 32'h07);
    send_rx(8'ha3, 1'b1, 1'b1, 1'b1, 2);
    bus_read(USR, d);
    check("par_ok_usr", d & 32'h71, 32'h00);
    bus_read(UDR, d);
    check("par_ok_data", d, 32'ha3);
    bus_read(UDR, d);
    check("udr_empty_read", d, 32'h0);
    send_rx(8'ha3, 1'b1, 1'b0, 1'b1, 2);
    bus_read(USR, d);
    check("par_bad_pe", d & 32'h70, 32'h10);
    bus_read(UDR, d);
    check("par_bad_data", d, 32'ha3);
    bus_write(USR, 32'h10);
    bus_read(USR, d);
    check("pe_cleared", d & 32'h70, 32'h00);
    bus_write(UCR, 32'h00);
    send_rx(8'h3c, 1'b0, 1'b0, 1'b0, 1);
    bus_read(USR, d);
    check("fe_set", d & 32'h70, 32'h20);
    check("fe_rxcnt", (d >> 8) & 32'hff, 32'd1);
    bus_read(UDR, d);
    check("fe_data", d, 32'h3c);
    bus_write(USR, 32'h70);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(USR, d);
    check("glitch_usr", d & 32'hff71, 32'h0001);
    bus_write(UCR, 32'h10);
    fork
      send_rx(rx_vec[0], 1'b0, 1'b0, 1'b1, 1);
      begin
        for (int n = 0; n < 400 && rxFfEmpty; n++) @(negedge clk);
        check("first_push", {31'b0, rxFfEmpty}, 32'd0);
        check("irq_before", {31'b0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'b0, irq}, 32'd1);
      end
    join
    for (int i = 1; i < 17; i++) send_rx(rx_vec[i], 1'b0, 1'b0, 1'b1, 1);
    bus_read(USR, d);
    check("ovf_rxcnt", (d >> 8) & 32'hff, 32'd16);
    check("ovf_oe", d & 32'h40, 32'h40);
    for (int i = 0; i < 16; i++) begin
      bus_read(UDR, d);
      check("fifo_order", d, {24'b0, rx_vec[i]});
    end
    check("irq_last_pop", {31'b0, irq}, 32'd1);
    @(negedge clk);
    check("irq_fall", {31'b0, irq}, 32'd0);
    bus_write(UDR, 32'haa);
    fork
      send_rx(8'h5a, 1'b0, 1'b0, 1'b1, 1);
      begin
        repeat (24) @(negedge clk);
        check("tx_pre_rst", {31'b0, tx}, 32'd0);
        rst = 1'b1;
        rx_idle = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", {31'b0, tx}, 32'd1);
        check("rst_mid_rxe", {31'b0, rxFfEmpty}, 32'd1);
        rst = 1'b0;
      end
    join
    repeat (100) @(negedge clk);
    check("post_rst_tx", {31'b0, tx}, 32'd1);
    check("post_rst_irq", {31'b0, irq}, 32'd0);
    bus_read(USR, d);
    check("post_rst_usr", d, 32'h05);
    bus_read(UBR, d);
    check("post_rst_ubr", d, 32'd868);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
